// File: rtl/mainbus_pkg.sv
// mainbus_pkg: shared main-bus definitions.
// Holds the requester vector type, the arbiter state encoding, the default
// burst / address-timeout constants and the round-robin pick helper used by
// mainbus_arbiter.
package mainbus_pkg;

    // Number of main-bus requesters.
    localparam int unsigned NUM_MASTERS = 2;

    // Default data-phase length and ADDR-state timeout (in clk cycles).
    localparam int unsigned DEFAULT_BURST_LEN    = 4;
    localparam int unsigned DEFAULT_ADDR_TIMEOUT = 4;

    typedef logic [NUM_MASTERS-1:0] req_vec_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        TURN = 2'd3
    } arb_state_t;

    // Round-robin pick between two requesters. last_gnt is the index of the
    // requester granted most recently; on contention the other one wins.
    function automatic req_vec_t rr_pick(input req_vec_t req, input logic last_gnt);
        req_vec_t pick;
        unique case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = last_gnt ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
        return pick;
    endfunction

endpackage

// File: rtl/mainbus_arbiter.sv
// mainbus_arbiter: two-requester round-robin main-bus arbiter.
// Sequence per transaction: IDLE -> ADDR -> DATA (BURST_LEN beats) -> TURN,
// with ADDR abandoned to TURN after ADDR_TIMEOUT cycles without AddrValid.
// Ports:
//   clk        system clock, rising edge
//   resetH     asynchronous active-high reset
//   req[1:0]   request lines, req[i] high while requester i wants the bus
//   AddrValid  address strobe from the granted requester (used in ADDR only)
//   gnt[1:0]   registered grant, one-hot or zero, held through ADDR and DATA
//   busy       high whenever the arbiter is not IDLE
//   data_phase high in DATA
//   beat[2:0]  current data-beat index in DATA, 0 elsewhere
//   timeout    single-cycle pulse in the TURN cycle after an ADDR timeout
module mainbus_arbiter
    import mainbus_pkg::*;
#(
    parameter int unsigned BURST_LEN    = DEFAULT_BURST_LEN,
    parameter int unsigned ADDR_TIMEOUT = DEFAULT_ADDR_TIMEOUT
) (
    input  logic       clk,
    input  logic       resetH,
    input  logic [1:0] req,
    input  logic       AddrValid,
    output logic [1:0] gnt,
    output logic       busy,
    output logic       data_phase,
    output logic [2:0] beat,
    output logic       timeout
);

    localparam logic [2:0] BEAT_LAST = 3'(BURST_LEN - 1);
    localparam logic [3:0] TCNT_LAST = 4'(ADDR_TIMEOUT - 1);

    arb_state_t state;
    logic [3:0] tcnt;      // ADDR cycles seen without AddrValid
    logic       last_gnt;  // index of most recently granted requester
    req_vec_t   pick;

    assign pick = rr_pick(req, last_gnt);

    always_ff @(posedge clk or posedge resetH) begin
        if (resetH) begin
            state    <= IDLE;
            gnt      <= '0;
            beat     <= '0;
            timeout  <= 1'b0;
            tcnt     <= '0;
            // Pretend requester 1 went last so requester 0 is favoured.
            last_gnt <= 1'b1;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (req != '0) begin
                        state    <= ADDR;
                        gnt      <= pick;
                        last_gnt <= pick[1];
                        tcnt     <= '0;
                    end
                end
                ADDR: begin
                    if (AddrValid) begin
                        state <= DATA;
                        beat  <= '0;
                    end else if (tcnt == TCNT_LAST) begin
                        state   <= TURN;
                        gnt     <= '0;
                        timeout <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 4'd1;
                    end
                end
                DATA: begin
                    if (beat == BEAT_LAST) begin
                        state <= TURN;
                        gnt   <= '0;
                        beat  <= '0;
                    end else begin
                        beat <= beat + 3'd1;
                    end
                end
                TURN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    beat  <= '0;
                end
            endcase
        end
    end

    // Decoded straight from the state register, so reset clears them at once.
    assign busy       = (state != IDLE);
    assign data_phase = (state == DATA);

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (resetH) $onehot0(gnt))
        else $error("gnt has more than one bit set");
    a_beat_range: assert property (@(posedge clk) disable iff (resetH) beat <= BEAT_LAST)
        else $error("beat out of range");
    a_data_gnt: assert property (@(posedge clk) disable iff (resetH) data_phase |-> (gnt != '0))
        else $error("data_phase without grant");

endmodule

// File: tb/tb_mainbus_arbiter.sv
// Directed testbench for mainbus_arbiter with default parameters
// (BURST_LEN=4, ADDR_TIMEOUT=4).
module tb_mainbus_arbiter;

    logic       clk;
    logic       resetH;
    logic [1:0] req;
    logic       AddrValid;
    logic [1:0] gnt;
    logic       busy;
    logic       data_phase;
    logic [2:0] beat;
    logic       timeout;

    int errors = 0;
    int checks = 0;

    mainbus_arbiter #(.BURST_LEN(4), .ADDR_TIMEOUT(4)) dut (
        .clk        (clk),
        .resetH     (resetH),
        .req        (req),
        .AddrValid  (AddrValid),
        .gnt        (gnt),
        .busy       (busy),
        .data_phase (data_phase),
        .beat       (beat),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: busy=%b after %0d cycles, required 0", name, busy, n);
        end
    endtask

    task automatic test_reset();
        resetH = 1'b1; req = 2'b00; AddrValid = 1'b0;
        tick();
        checks++;
        if ({gnt, busy, data_phase, beat, timeout} !== 8'b0) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b busy=%b dp=%b beat=%0d to=%b, required all 0",
                     gnt, busy, data_phase, beat, timeout);
        end
        resetH = 1'b0;
        AddrValid = 1'b1;   // ignored in IDLE
        tick();
        checks++;
        if (busy !== 1'b0 || gnt !== 2'b00) begin
            errors++;
            $display("FAIL idle_ignore_av: busy=%b gnt=%b, required 0/00", busy, gnt);
        end
        AddrValid = 1'b0;
    endtask

    task automatic test_single();
        req = 2'b01; AddrValid = 1'b1;
        tick();
        checks++;
        if (gnt !== 2'b01 || busy !== 1'b1 || data_phase !== 1'b0) begin
            errors++;
            $display("FAIL single_addr: gnt=%b busy=%b dp=%b, required 01/1/0", gnt, busy, data_phase);
        end
        for (int b = 0; b < 4; b++) begin
            tick();
            checks++;
            if (gnt !== 2'b01 || data_phase !== 1'b1 || beat !== 3'(b)) begin
                errors++;
                $display("FAIL single_beat%0d: gnt=%b dp=%b beat=%0d, required 01/1/%0d",
                         b, gnt, data_phase, beat, b);
            end
        end
        req = 2'b00;
        tick();
        checks++;
        if (gnt !== 2'b00 || busy !== 1'b1 || data_phase !== 1'b0 || beat !== 3'd0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL single_turn: gnt=%b busy=%b dp=%b beat=%0d to=%b, required 00/1/0/0/0",
                     gnt, busy, data_phase, beat, timeout);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || gnt !== 2'b00) begin
            errors++;
            $display("FAIL single_idle: busy=%b gnt=%b, required 0/00", busy, gnt);
        end
        AddrValid = 1'b0;
    endtask

    task automatic test_contention();
        logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [1:0] prev = 2'b00;
        int gcount = 0;
        int gap = 0;
        resetH = 1'b1;
        tick();
        resetH = 1'b0;
        req = 2'b11; AddrValid = 1'b1;
        for (int c = 0; c < 60 && gcount < 4; c++) begin
            tick();
            if (c == 0) begin
                checks++;
                if (gnt !== 2'b01) begin
                    errors++;
                    $display("FAIL contend_first_latency: gnt=%b, required 01", gnt);
                end
            end
            if (gnt !== 2'b00 && prev === 2'b00) begin
                checks++;
                if (gnt !== exp_g[gcount]) begin
                    errors++;
                    $display("FAIL contend_grant%0d: gnt=%b, required %b", gcount, gnt, exp_g[gcount]);
                end
                if (gcount > 0) begin
                    checks++;
                    if (gap < 2) begin
                        errors++;
                        $display("FAIL contend_gap%0d: gap=%0d, required >=2", gcount, gap);
                    end
                end
                gcount++;
                gap = 0;
            end else if (gnt !== 2'b00) begin
                checks++;
                if (gnt !== prev) begin
                    errors++;
                    $display("FAIL contend_hold: gnt=%b, required %b", gnt, prev);
                end
            end else begin
                gap++;
            end
            prev = gnt;
        end
        checks++;
        if (gcount != 4) begin
            errors++;
            $display("FAIL contend_count: grants=%0d, required 4", gcount);
        end
        req = 2'b00;
        wait_idle("contend");
        AddrValid = 1'b0;
    endtask

    task automatic test_timeout();
        int gcnt = 0;
        int pulses = 0;
        resetH = 1'b1;
        tick();
        resetH = 1'b0;
        req = 2'b10; AddrValid = 1'b0;
        tick();
        checks++;
        if (gnt !== 2'b10) begin
            errors++;
            $display("FAIL timeout_grant: gnt=%b, required 10", gnt);
        end
        gcnt = 1;
        req = 2'b00;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (gnt === 2'b10) gcnt++;
            if (timeout === 1'b1) begin
                pulses++;
                checks++;
                if (gnt !== 2'b00 || busy !== 1'b1 || data_phase !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_in_turn: gnt=%b busy=%b dp=%b, required 00/1/0",
                             gnt, busy, data_phase);
                end
            end
        end
        checks++;
        if (gcnt != 4) begin
            errors++;
            $display("FAIL timeout_gnt_cycles: got %0d, required 4", gcnt);
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL timeout_pulses: got %0d, required 1", pulses);
        end
        req = 2'b11; AddrValid = 1'b1;
        tick();
        checks++;
        if (gnt !== 2'b01) begin
            errors++;
            $display("FAIL timeout_pointer: gnt=%b, required 01", gnt);
        end
        req = 2'b00;
        wait_idle("timeout");
        AddrValid = 1'b0;
    endtask

    task automatic test_req_drop();
        req = 2'b01; AddrValid = 1'b1;
        tick();   // ADDR
        tick();   // beat 0
        tick();   // beat 1
        checks++;
        if (beat !== 3'd1 || gnt !== 2'b01) begin
            errors++;
            $display("FAIL drop_beat1: beat=%0d gnt=%b, required 1/01", beat, gnt);
        end
        req = 2'b00;
        for (int b = 2; b < 4; b++) begin
            tick();
            checks++;
            if (beat !== 3'(b) || gnt !== 2'b01 || data_phase !== 1'b1) begin
                errors++;
                $display("FAIL drop_beat%0d: beat=%0d gnt=%b dp=%b, required %0d/01/1",
                         b, beat, gnt, data_phase, b);
            end
        end
        tick();
        checks++;
        if (gnt !== 2'b00 || busy !== 1'b1) begin
            errors++;
            $display("FAIL drop_turn: gnt=%b busy=%b, required 00/1", gnt, busy);
        end
        wait_idle("drop");
        AddrValid = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        req = 2'b01; AddrValid = 1'b1;
        tick(); tick(); tick(); tick();
        checks++;
        if (beat !== 3'd2 || gnt !== 2'b01) begin
            errors++;
            $display("FAIL rst_pre_beat2: beat=%0d gnt=%b, required 2/01", beat, gnt);
        end
        #2 resetH = 1'b1;
        #1;
        checks++;
        if (gnt !== 2'b00 || busy !== 1'b0 || data_phase !== 1'b0 || beat !== 3'd0) begin
            errors++;
            $display("FAIL rst_async: gnt=%b busy=%b dp=%b beat=%0d, required 00/0/0/0",
                     gnt, busy, data_phase, beat);
        end
        req = 2'b11;
        tick();
        resetH = 1'b0;
        tick();
        checks++;
        if (gnt !== 2'b01) begin
            errors++;
            $display("FAIL rst_priority: gnt=%b, required 01", gnt);
        end
        req = 2'b00;
        wait_idle("rst");
        AddrValid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_timeout();
        test_req_drop();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mainbus_arbiter.md
MAINBUS_ARBITER -- requirements
Module: mainbus_arbiter

Interface
REQ-001 The block SHALL have parameter BURST_LEN, default 4, giving the number of data-phase cycles per transaction (legal range 1..8).
REQ-002 The block SHALL have parameter ADDR_TIMEOUT, default 4, giving the number of ADDR-state cycles allowed without AddrValid before the grant is revoked (legal range 1..15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port resetH, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port req, input, 2 bits: req[i] is high while requester i wants the main bus.
REQ-006 The block SHALL have port AddrValid, input, 1 bit: the main-bus address strobe, driven by the granted requester.
REQ-007 The block SHALL have port gnt, output, 2 bits: registered, one-hot or zero; gnt[i] means requester i owns the bus.
REQ-008 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-009 The block SHALL have port data_phase, output, 1 bit: high in the DATA state only.
REQ-010 The block SHALL have port beat, output, 3 bits: the current data-beat index (0..BURST_LEN-1) in DATA, and 0 in all other states.
REQ-011 The block SHALL have port timeout, output, 1 bit: a registered single-cycle pulse when ADDR_TIMEOUT expires.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, ADDR, DATA, TURN.
- IDLE -> ADDR when req != 0.
- ADDR -> DATA when AddrValid is high.
- ADDR -> TURN when AddrValid has been absent for ADDR_TIMEOUT consecutive ADDR cycles.
- DATA -> TURN after BURST_LEN cycles in DATA.
- TURN -> IDLE unconditionally, after exactly one cycle.
REQ-013 Arbitration SHALL occur only in IDLE; the winner's gnt bit SHALL be high in the first ADDR cycle, i.e. one cycle after req is sampled.
REQ-014 Arbitration SHALL be round-robin.
- Single requester: that requester wins.
- Both requesting: the requester not granted most recently wins.
- After reset, requester 0 has priority.
REQ-015 The last-grant pointer SHALL update only on IDLE -> ADDR, including for transactions that later time out.
REQ-016 gnt SHALL stay constant through ADDR and DATA.
REQ-017 gnt SHALL be 2'b00 in TURN and IDLE; the TURN cycle guarantees a one-cycle tri-state turnaround with no driver between owners.
REQ-018 Deassertion of req[i] during ADDR or DATA SHALL NOT shorten the transaction; the burst always runs the full BURST_LEN beats.
REQ-019 AddrValid SHALL be ignored in IDLE, DATA and TURN.
REQ-020 beat SHALL be 0 on DATA entry and increment by 1 per DATA cycle; it SHALL never exceed BURST_LEN-1.
REQ-021 The ADDR timeout counter SHALL clear on ADDR entry; timeout SHALL pulse in the TURN cycle that follows a timeout, and at no other time.
REQ-022 Back-to-back transactions SHALL be separated by at least TURN + IDLE, so the minimum gnt-low gap is 2 cycles.
REQ-023 gnt SHALL never have both bits set, in any state.
REQ-024 When req is high in TURN, it SHALL be serviced on the following IDLE cycle; the TURN cycle is not skipped.

Reset
REQ-025 While resetH is high, all outputs SHALL be held asynchronously at: state IDLE, gnt=00, busy=0, data_phase=0, beat=0, timeout=0.
REQ-026 Reset SHALL clear the last-grant pointer so that requester 0 is favoured next.
REQ-027 Reset asserted mid-ADDR or mid-DATA SHALL drop gnt immediately, without waiting for a clock edge.
REQ-028 After resetH falls, the first arbitration SHALL occur on the first rising clk edge with req != 0.

Structure
REQ-029 The state enum arb_state_t and the default BURST_LEN/ADDR_TIMEOUT constants SHALL live in a shared package, mainbus_pkg, alongside the existing bus definitions.
REQ-030 The block SHALL be a single module with no sub-modules; the round-robin pointer, beat counter and timeout counter are inline registers.
REQ-031 Next-state logic SHALL be fully specified in every state, so that no latches are inferred.

Verification
REQ-032 Single requester: req=01, AddrValid high in the first ADDR cycle -> gnt=01 for 1+4 cycles, beat=0,1,2,3, then TURN with gnt=00, then IDLE.
REQ-033 Contention: req=11 held after reset -> grant order 01, 10, 01, 10, with a gap of at least 2 cycles between grants.
REQ-034 Timeout: req=10, AddrValid never asserted -> gnt=10 for 4 cycles, timeout pulses once, pointer now favours requester 0.
REQ-035 Req drop: req=01 deasserted during beat 1 -> beats 2 and 3 still occur, and gnt=01 is held until TURN.
REQ-036 Reset mid-burst: resetH raised during beat 2 -> gnt=00 and busy=0 immediately; after release with req=11, requester 0 wins.
REQ-037 Assertions SHALL check, every cycle, that gnt is one-hot or zero, that beat < BURST_LEN, and that data_phase implies gnt != 0.
